// File: rtl/cr16_ctrl_fsm_ls_if.sv
// rtl/cr16_ctrl_fsm_ls_if.sv - unified-memory handshake between the control FSM and memory
interface cr16_ctrl_fsm_ls_if;
  logic [15:0] instr;
  logic        mem_ready;
  logic        mem_re;
  logic        mem_we;
  logic        addr_sel;

  modport master (
    input  instr,
    input  mem_ready,
    output mem_re,
    output mem_we,
    output addr_sel
  );

  modport slave (
    output instr,
    output mem_ready,
    input  mem_re,
    input  mem_we,
    input  addr_sel
  );
endinterface

// File: rtl/cr16_ctrl_fsm_ls.sv
// rtl/cr16_ctrl_fsm_ls.sv - multi-cycle CR16-subset control FSM with IR, LOAD/STOR, Bcond/Jcond, retire limit
// Optional macro CTRL_WAIT_TIMEOUT_EN bounds memory waits and raises a sticky err.
module cr16_ctrl_fsm_ls #(
  parameter int REG_CNT    = 16,
  parameter int MAX_INSTRS = 0,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  cr16_ctrl_fsm_ls_if.master    mem,
  input  logic [4:0]            flags,
  output logic                  pc_en,
  output logic                  pc_ld,
  output logic                  pc_sel,
  output logic                  wb_sel,
  output logic                  reg_we,
  output logic [REG_CNT-1:0]    reg_en,
  output logic                  imm_en,
  output logic [3:0]            op,
  output logic [3:0]            rdest,
  output logic [3:0]            rsrc,
  output logic [7:0]            imm8,
  output logic                  halted,
  output logic                  err,
  output logic [CNT_W-1:0]      instr_count
);

  if (REG_CNT < 2 || REG_CNT > 16) begin : g_bad_reg_cnt
    $error("REG_CNT must be in 2..16");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_HALT
  } state_t;

  state_t          state, state_next;
  logic [15:0]     ir;
  logic [CNT_W-1:0] cnt_inc;
  logic            is_rtype, is_load, is_stor, is_jcond, is_bcond;
  logic            alu_writes, taken, retire, halt_hit, timeout_hit;
  logic            mem_re_c, mem_we_c, addr_sel_c;
  logic            f_c, f_l, f_f, f_z, f_n;

  assign is_rtype = (ir[15:12] == 4'h0);
  assign is_load  = (ir[15:12] == 4'h4) && (ir[7:4] == 4'h0);
  assign is_stor  = (ir[15:12] == 4'h4) && (ir[7:4] == 4'h4);
  assign is_jcond = (ir[15:12] == 4'h4) && (ir[7:4] == 4'hC);
  assign is_bcond = (ir[15:12] == 4'hC);

  assign op         = is_rtype ? ir[7:4] : ir[15:12];
  assign imm_en     = !(is_rtype || is_load || is_stor || is_jcond || is_bcond);
  assign rdest      = ir[11:8];
  assign rsrc       = ir[3:0];
  assign imm8       = ir[7:0];
  // CMP only updates flags and NOP does nothing, so neither writes back
  assign alu_writes = (op != 4'hB) && (op != 4'h0);

  assign {f_c, f_l, f_f, f_z, f_n} = flags;

  always_comb begin
    taken = 1'b0;
    case (ir[11:8])
      4'h0: taken = f_z;
      4'h1: taken = !f_z;
      4'h2: taken = f_c;
      4'h3: taken = !f_c;
      4'h4: taken = f_l;
      4'h5: taken = !f_l;
      4'h6: taken = f_n;
      4'h7: taken = !f_n;
      4'h8: taken = f_f;
      4'h9: taken = !f_f;
      4'hA: taken = !f_l && !f_z;
      4'hB: taken = f_l || f_z;
      4'hC: taken = !f_n && !f_z;
      4'hD: taken = f_n || f_z;
      4'hE: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign retire   = pc_en || pc_ld;
  assign cnt_inc  = instr_count + 1'b1;
  assign halt_hit = (MAX_INSTRS != 0) && (cnt_inc == CNT_W'(MAX_INSTRS));

`ifdef CTRL_WAIT_TIMEOUT_EN
  localparam int WAIT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [WAIT_W-1:0] wait_cnt;
  logic              err_q;
  logic              stalled;

  assign stalled     = ((state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR)) && !mem.mem_ready;
  assign timeout_hit = stalled && (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign err         = err_q;

  // A stalled state never changes except on timeout, so clearing on !stalled covers every exit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= stalled ? wait_cnt + 1'b1 : '0;
      if (timeout_hit) err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_FETCH;
      ir          <= '0;
      instr_count <= '0;
    end else begin
      state <= state_next;
      if (state == S_FETCH && mem.mem_ready) ir <= mem.instr;
      if (retire) instr_count <= cnt_inc;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (mem.mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        if (is_load)                    state_next = S_MEM_RD;
        else if (is_stor)               state_next = S_MEM_WR;
        else if (is_jcond || is_bcond)  state_next = S_BRANCH;
        else                            state_next = S_EXEC;
      end
      S_EXEC:   state_next = S_FETCH;
      S_MEM_RD: if (mem.mem_ready) state_next = S_MEM_WB;
      S_MEM_WB: state_next = S_FETCH;
      S_MEM_WR: if (mem.mem_ready) state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
    if (retire && halt_hit) state_next = S_HALT;
    if (timeout_hit)        state_next = S_HALT;
  end

  always_comb begin
    pc_en      = 1'b0;
    pc_ld      = 1'b0;
    pc_sel     = 1'b0;
    wb_sel     = 1'b0;
    reg_we     = 1'b0;
    halted     = 1'b0;
    mem_re_c   = 1'b0;
    mem_we_c   = 1'b0;
    addr_sel_c = 1'b0;
    case (state)
      S_FETCH:  mem_re_c = 1'b1;
      S_EXEC: begin
        pc_en  = 1'b1;
        reg_we = alu_writes;
      end
      S_MEM_RD: begin
        addr_sel_c = 1'b1;
        mem_re_c   = 1'b1;
      end
      S_MEM_WB: begin
        wb_sel = 1'b1;
        reg_we = 1'b1;
        pc_en  = 1'b1;
      end
      S_MEM_WR: begin
        addr_sel_c = 1'b1;
        mem_we_c   = 1'b1;
        pc_en      = mem.mem_ready;
      end
      S_BRANCH: begin
        pc_ld  = taken;
        pc_en  = !taken;
        pc_sel = taken && is_jcond;
      end
      S_HALT:   halted = 1'b1;
      default:  ;
    endcase
  end

  assign reg_en       = reg_we ? (REG_CNT'(1) << rdest) : '0;
  assign mem.mem_re   = mem_re_c;
  assign mem.mem_we   = mem_we_c;
  assign mem.addr_sel = addr_sel_c;

endmodule
